// File: rtl/arith_pkg.sv
// arith_pkg: shared widths and lookahead carry helper for the CLA adder family
package arith_pkg;
   localparam int CLA_GROUP_W = 4;
   localparam int CLA_W = 8;
   // returns {c4,c3,c2,c1,c0} for one 4-bit group, each carry flattened to two-level logic
   function automatic logic [CLA_GROUP_W:0] cla_carry(
      input logic [CLA_GROUP_W-1:0] p,
      input logic [CLA_GROUP_W-1:0] g,
      input logic                   cin
   );
      logic [CLA_GROUP_W:0] c;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      return c;
   endfunction
endpackage

// File: rtl/cla_4bit.sv
// cla_4bit: 4-bit lookahead group producing sum, group P/G and the top internal carry
module cla_4bit
   import arith_pkg::*;
(
   input  logic [CLA_GROUP_W-1:0] a,
   input  logic [CLA_GROUP_W-1:0] b,
   input  logic                   cin,
   output logic [CLA_GROUP_W-1:0] s,
   output logic                   pg,
   output logic                   gg,
   output logic                   c3
);
   logic [CLA_GROUP_W-1:0] p;
   logic [CLA_GROUP_W-1:0] g;
   logic [CLA_GROUP_W:0]   c;
   always_comb begin
      p  = a ^ b;
      g  = a & b;
      c  = cla_carry(p, g, cin);
      s  = p ^ c[CLA_GROUP_W-1:0];
      c3 = c[3];
      pg = &p;
      // group generate must not depend on cin so the second level can use it
      gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   end
endmodule

// File: rtl/cla_8bit.sv
// cla_8bit: 8-bit two-level carry-lookahead adder with combinational and registered results
module cla_8bit
   import arith_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [CLA_W-1:0] A,
   input  logic [CLA_W-1:0] B,
   input  logic             Cin,
   output logic [CLA_W-1:0] Sum,
   output logic             Cout,
   output logic             Pg,
   output logic             Gg,
   output logic             Ovf,
   output logic [CLA_W-1:0] Sum_q,
   output logic             Cout_q,
   output logic             Ovf_q
);
   logic [CLA_GROUP_W-1:0] s_lo, s_hi;
   logic                   pg_lo, gg_lo, pg_hi, gg_hi;
   logic                   c3_lo, c7, c4, c8;
   logic [CLA_W-1:0]       sum_d;
   logic                   cout_d, ovf_d;

   cla_4bit u_lo (
      .a  (A[CLA_GROUP_W-1:0]),
      .b  (B[CLA_GROUP_W-1:0]),
      .cin(Cin),
      .s  (s_lo),
      .pg (pg_lo),
      .gg (gg_lo),
      .c3 (c3_lo)
   );

   cla_4bit u_hi (
      .a  (A[CLA_W-1:CLA_GROUP_W]),
      .b  (B[CLA_W-1:CLA_GROUP_W]),
      .cin(c4),
      .s  (s_hi),
      .pg (pg_hi),
      .gg (gg_hi),
      .c3 (c7)
   );

   // second-level lookahead: c4 and c8 come straight from group P/G and Cin
   always_comb begin
      c4     = gg_lo | (pg_lo & Cin);
      c8     = gg_hi | (pg_hi & gg_lo) | (pg_hi & pg_lo & Cin);
      Sum    = {s_hi, s_lo};
      Cout   = c8;
      Pg     = pg_hi & pg_lo;
      Gg     = gg_hi | (pg_hi & gg_lo);
      Ovf    = c7 ^ c8;
      sum_d  = Sum;
      cout_d = Cout;
      ovf_d  = Ovf;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         Sum_q  <= '0;
         Cout_q <= 1'b0;
         Ovf_q  <= 1'b0;
      end else begin
         Sum_q  <= sum_d;
         Cout_q <= cout_d;
         Ovf_q  <= ovf_d;
      end
   end
endmodule

// File: tb/tb_cla_8bit.sv
// tb_cla_8bit: directed table, clocked reset sequences, random registered checks and exhaustive sweep
module tb_cla_8bit;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] A, B;
   logic       Cin;
   logic [7:0] Sum, Sum_q;
   logic       Cout, Pg, Gg, Ovf, Cout_q, Ovf_q;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
      logic       pg;
      logic       gg;
      logic       ovf;
   } vec_t;

   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       pg;
      logic       gg;
      logic       ovf;
   } res_t;

   cla_8bit dut (
      .clk   (clk),
      .rst   (rst),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
      .Sum   (Sum),
      .Cout  (Cout),
      .Pg    (Pg),
      .Gg    (Gg),
      .Ovf   (Ovf),
      .Sum_q (Sum_q),
      .Cout_q(Cout_q),
      .Ovf_q (Ovf_q)
   );

   always #5 clk = ~clk;

   // reference from plain integer arithmetic
   function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic cin);
      res_t r;
      int   u, sv;
      u  = int'(a) + int'(b) + int'(cin);
      sv = int'($signed(a)) + int'($signed(b)) + int'(cin);
      r.sum  = u[7:0];
      r.cout = u > 255;
      r.pg   = (a ^ b) == 8'hFF;
      r.gg   = (int'(a) + int'(b)) > 255;
      r.ovf  = (sv > 127) || (sv < -128);
      return r;
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (A=%h B=%h Cin=%b)", name, got, exp, A, B, Cin);
      end
   endtask

   task automatic check_comb(input string tag, input res_t e);
      check({tag, " Sum"}, Sum, e.sum);
      check({tag, " Cout"}, {7'd0, Cout}, {7'd0, e.cout});
      check({tag, " Pg"}, {7'd0, Pg}, {7'd0, e.pg});
      check({tag, " Gg"}, {7'd0, Gg}, {7'd0, e.gg});
      check({tag, " Ovf"}, {7'd0, Ovf}, {7'd0, e.ovf});
   endtask

   task automatic check_regs(input string tag, input logic [7:0] s, input logic c, input logic o);
      check({tag, " Sum_q"}, Sum_q, s);
      check({tag, " Cout_q"}, {7'd0, Cout_q}, {7'd0, c});
      check({tag, " Ovf_q"}, {7'd0, Ovf_q}, {7'd0, o});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t tbl[10];
      res_t e;
      logic [7:0] ps;
      logic pc, po;
      tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{8'h0F, 8'h0F, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{8'h64, 8'h1C, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[8] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[9] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1};

      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         A = tbl[i].a;
         B = tbl[i].b;
         Cin = tbl[i].cin;
         #1;
         e.sum = tbl[i].sum;
         e.cout = tbl[i].cout;
         e.pg = tbl[i].pg;
         e.gg = tbl[i].gg;
         e.ovf = tbl[i].ovf;
         check_comb("table", e);
      end

      @(negedge clk);
      rst = 1'b1;
      A = 8'hAA;
      B = 8'h77;
      Cin = 1'b1;
      tick();
      tick();
      check_regs("reset", 8'h00, 1'b0, 1'b0);
      check("reset comb Sum", Sum, 8'h22);
      rst = 1'b0;
      A = 8'h0F;
      B = 8'h0F;
      Cin = 1'b0;
      tick();
      check_regs("load", 8'h1E, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      check_regs("midreset", 8'h00, 1'b0, 1'b0);
      check("midreset comb Sum", Sum, 8'h1E);
      rst = 1'b0;
      A = 8'h80;
      B = 8'hFF;
      Cin = 1'b0;
      tick();
      check_regs("after reset", 8'h7F, 1'b1, 1'b1);

      ps = 8'h7F;
      pc = 1'b1;
      po = 1'b1;
      for (int i = 0; i < 300; i++) begin
         A = 8'($urandom);
         B = 8'($urandom);
         Cin = 1'($urandom);
         rst = ($urandom_range(0, 9) == 0);
         #1;
         check_regs("hold", ps, pc, po);
         e = model(A, B, Cin);
         check_comb("rand", e);
         tick();
         ps = rst ? 8'h00 : e.sum;
         pc = rst ? 1'b0 : e.cout;
         po = rst ? 1'b0 : e.ovf;
         check_regs("rand", ps, pc, po);
      end
      rst = 1'b0;

      for (int a = 0; a < 256; a++)
         for (int b = 0; b < 256; b++)
            for (int c = 0; c < 2; c++) begin
               A = 8'(a);
               B = 8'(b);
               Cin = 1'(c);
               #1;
               e = model(A, B, Cin);
               check("sweep Sum", Sum, e.sum);
               check("sweep Cout", {7'd0, Cout}, {7'd0, e.cout});
               check("sweep Ovf", {7'd0, Ovf}, {7'd0, e.ovf});
               check("sweep Gg|Pg&Cin", {7'd0, Gg | (Pg & Cin)}, {7'd0, e.cout});
            end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
